// File: rtl/key_text_buffer_if.sv
// Byte-input handshake and display read port of key_text_buffer.
// master: the keyboard decoder / display side driving the buffer.
// slave:  the buffer itself.
interface key_text_buffer_if #(
  parameter int AW = 5
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  modport master (
    output in_valid,
    output in_data,
    output rd_addr,
    input  in_ready,
    input  rd_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  rd_addr,
    output in_ready,
    output rd_data
  );
endinterface

// File: rtl/key_text_buffer.sv
// key_text_buffer: line-editing text buffer fed by the keyboard decoder.
// Printable bytes are appended at the cursor, backspace erases the previous
// character, and enter blanks the whole line one address per cycle.
// A registered read port serves the text display stage.
// Optional feature macro: CURSOR_BLINK_EN (adds the cursor blink timer;
// when undefined, cur_blink is tied low and no timer exists).
module key_text_buffer #(
  parameter int DEPTH      = 32,
  parameter int AW         = 5,
  parameter int BLINK_HALF = 12500000
) (
  input  logic          clk,
  input  logic          rst_n,
  key_text_buffer_if.slave bus,
  output logic [AW:0]   cursor,
  output logic          line_full,
  output logic          overflow,
  output logic          clearing,
  output logic          cur_blink
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [AW:0]   cursor_n;
  logic          overflow_n;
  logic [AW-1:0] clr_addr, clr_addr_n;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [7:0]    rd_q;
  logic          accept;
  logic          printable;

  logic [7:0] ram [DEPTH];

  // The line is only editable in IDLE; INIT and CLEAR own the write port.
  assign bus.in_ready = (state == S_IDLE);
  assign clearing     = (state != S_IDLE);
  assign line_full    = (cursor == (AW+1)'(DEPTH));
  assign accept       = bus.in_valid & bus.in_ready;
  assign printable    = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
  assign bus.rd_data  = rd_q;

  // State, cursor, sticky overflow and blanking address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      cursor   <= '0;
      overflow <= 1'b0;
      clr_addr <= '0;
    end else begin
      state    <= state_n;
      cursor   <= cursor_n;
      overflow <= overflow_n;
      clr_addr <= clr_addr_n;
    end
  end

  // Next-state and write-port decode: blanking sweep or edit command.
  always_comb begin
    state_n    = state;
    cursor_n   = cursor;
    overflow_n = overflow;
    clr_addr_n = clr_addr;
    we         = 1'b0;
    waddr      = clr_addr;
    wdata      = 8'h20;
    case (state)
      S_INIT, S_CLEAR: begin
        we         = 1'b1;
        clr_addr_n = clr_addr + 1'b1;
        if (clr_addr == AW'(DEPTH - 1)) begin
          state_n    = S_IDLE;
          cursor_n   = '0;
          overflow_n = 1'b0;
        end
      end
      S_IDLE: begin
        if (accept) begin
          if (printable) begin
            if (!line_full) begin
              we       = 1'b1;
              waddr    = cursor[AW-1:0];
              wdata    = bus.in_data;
              cursor_n = cursor + 1'b1;
            end else begin
              overflow_n = 1'b1;
            end
          end else if (bus.in_data == 8'h08) begin
            if (cursor != '0) begin
              we       = 1'b1;
              waddr    = cursor[AW-1:0] - 1'b1;
              cursor_n = cursor - 1'b1;
            end
          end else if (bus.in_data == 8'h0D) begin
            state_n = S_CLEAR;
          end
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  // Line RAM write port; contents are meaningless until INIT finishes.
  always_ff @(posedge clk) begin
    if (we) begin
      ram[waddr] <= wdata;
    end
  end

  // Registered display read, returns the pre-write value on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= 8'h20;
    end else begin
      rd_q <= ram[bus.rd_addr];
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  logic [BW-1:0] blink_cnt;

  // Blink timer restarts on every accepted byte so the cursor stays solid while typing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      cur_blink <= 1'b0;
    end else if (accept) begin
      blink_cnt <= '0;
      cur_blink <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      cur_blink <= ~cur_blink;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  assign cur_blink = 1'b0;
`endif

endmodule

// File: tb/tb_key_text_buffer.sv
// Self-checking bench for key_text_buffer: directed scenarios followed by a
// random keystroke stream, all compared against a line-editor model.
module tb_key_text_buffer;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk;
  logic          rst_n;
  logic [AW:0]   cursor;
  logic          line_full;
  logic          overflow;
  logic          clearing;
  logic          cur_blink;

  key_text_buffer_if #(.AW(AW)) bus ();

  key_text_buffer #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .BLINK_HALF(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .cursor   (cursor),
    .line_full(line_full),
    .overflow (overflow),
    .clearing (clearing),
    .cur_blink(cur_blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Line-editor model: the text line, the cursor and the sticky overflow flag.
  logic [7:0] modelLine [DEPTH];
  int         modelCursor;
  bit         modelOverflow;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelBlankLine();
    for (int i = 0; i < DEPTH; i++) modelLine[i] = 8'h20;
    modelCursor   = 0;
    modelOverflow = 0;
  endtask

  task automatic modelApply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      if (modelCursor < DEPTH) begin
        modelLine[modelCursor] = b;
        modelCursor++;
      end else begin
        modelOverflow = 1;
      end
    end else if (b == 8'h08) begin
      if (modelCursor > 0) begin
        modelCursor--;
        modelLine[modelCursor] = 8'h20;
      end
    end else if (b == 8'h0D) begin
      modelBlankLine();
    end
  endtask

  // Counts negedges until in_ready rises; bounded so a stuck DUT cannot hang the run.
  task automatic waitReady(output int cycles);
    cycles = 0;
    while (!bus.in_ready && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // One accepted byte: present at a negedge, the posedge between takes it.
  task automatic applyStimulus(input logic [7:0] b);
    int waited;
    waitReady(waited);
    checkOutput("ready_before_send", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    modelApply(b);
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, "_cursor"},   32'(cursor),    32'(modelCursor));
    checkOutput({tag, "_full"},     32'(line_full), 32'(modelCursor == DEPTH));
    checkOutput({tag, "_overflow"}, 32'(overflow),  32'(modelOverflow));
    checkOutput({tag, "_clearing"}, 32'(clearing),  32'd0);
    checkOutput({tag, "_ready"},    32'(bus.in_ready), 32'd1);
`ifndef CURSOR_BLINK_EN
    checkOutput({tag, "_blink"},    32'(cur_blink), 32'd0);
`endif
  endtask

  task automatic readAll(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_addr = AW'(i);
      @(negedge clk);
      checkOutput($sformatf("%s_rd%0d", tag, i), 32'(bus.rd_data), 32'(modelLine[i]));
    end
  endtask

  // After an accepted enter: the line must blank for exactly DEPTH cycles.
  task automatic clearWait(input string tag);
    int cycles;
    checkOutput({tag, "_clearing_on"}, 32'(clearing), 32'd1);
    waitReady(cycles);
    checkOutput({tag, "_clear_cycles"}, 32'(cycles), 32'(DEPTH));
  endtask

  initial begin
    int cycles;
    logic [7:0] b;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.rd_addr  = '0;
    rst_n        = 1'b0;

    // Reset values and INIT sweep length.
    repeat (3) @(negedge clk);
    checkOutput("rst_ready",    32'(bus.in_ready), 32'd0);
    checkOutput("rst_clearing", 32'(clearing),     32'd1);
    checkOutput("rst_cursor",   32'(cursor),       32'd0);
    checkOutput("rst_overflow", 32'(overflow),     32'd0);
    checkOutput("rst_rd_data",  32'(bus.rd_data),  32'h20);
    checkOutput("rst_blink",    32'(cur_blink),    32'd0);
    rst_n = 1'b1;
    waitReady(cycles);
    checkOutput("init_cycles", 32'(cycles), 32'(DEPTH));
    modelBlankLine();
    checkStatus("init");
    readAll("init");

    // "Hi" back to back.
    applyStimulus(8'h48);
    applyStimulus(8'h69);
    checkStatus("hi");
    checkOutput("hi_cursor_two", 32'(cursor), 32'd2);
    readAll("hi");

    // Backspaces, the third one at column 0.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h08);
      checkStatus($sformatf("bs%0d", i));
    end
    readAll("bs");

    // Fill the line and push one past it.
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(8'h41);
      if (i >= DEPTH - 1) checkStatus($sformatf("fill%0d", i));
    end
    checkOutput("fill_overflow_set", 32'(overflow), 32'd1);
    readAll("fill");

    // Enter with the next byte already waiting on the bus.
    applyStimulus(8'h0D);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    checkOutput("enter_clearing_on", 32'(clearing), 32'd1);
    cycles = 0;
    while (!bus.in_ready && cycles < 200) begin
      checkOutput("enter_held_cursor", 32'(cursor), 32'd32);
      @(negedge clk);
      cycles++;
    end
    checkOutput("enter_clear_cycles", 32'(cycles), 32'(DEPTH));
    checkStatus("enter_done");
    @(negedge clk);
    bus.in_valid = 1'b0;
    modelApply(8'h5A);
    checkStatus("held_byte");
    readAll("enter");

`ifdef CURSOR_BLINK_EN
    // Blink phase counted from the last accept.
    applyStimulus(8'h00);
    for (int k = 0; k < 20; k++) begin
      checkOutput($sformatf("blink_k%0d", k), 32'(cur_blink), 32'((k / 4) % 2));
      @(negedge clk);
    end
    applyStimulus(8'h42);
    checkOutput("blink_after_accept", 32'(cur_blink), 32'd0);
`endif

    // Reset pulse partway through a clear must restart the sweep from address 0.
    applyStimulus(8'h0D);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midclr_cursor",   32'(cursor),       32'd0);
    checkOutput("midclr_ready",    32'(bus.in_ready), 32'd0);
    checkOutput("midclr_clearing", 32'(clearing),     32'd1);
    checkOutput("midclr_rd_data",  32'(bus.rd_data),  32'h20);
    checkOutput("midclr_blink",    32'(cur_blink),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    waitReady(cycles);
    checkOutput("midclr_init_cycles", 32'(cycles), 32'(DEPTH));
    modelBlankLine();
    checkStatus("midclr");

    // Random keystroke stream.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 62)      b = 8'($urandom_range(32, 126));
      else if (r < 80) b = 8'h08;
      else if (r < 82) b = 8'h0D;
      else if (r < 91) b = 8'($urandom_range(0, 31));
      else             b = 8'($urandom_range(127, 255));
      applyStimulus(b);
      if (b == 8'h0D) clearWait($sformatf("rnd%0d", n));
      checkStatus($sformatf("rnd%0d", n));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      if ($urandom_range(0, 49) == 0) readAll($sformatf("rnd%0d", n));
    end
    readAll("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
